// File: rtl/ucode_pkg.sv
// Shared constants and state type for the MUL microcode expander.
package ucode_pkg;

    // Instruction class field values
    localparam logic [1:0] CLS_DIMM = 2'b00;
    localparam logic [1:0] CLS_DREG = 2'b01;

    // ALU function field values
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SHL = 3'b101;
    localparam logic [2:0] MOV = 3'b111;

    // Opcode of the MUL pseudo-instruction recognised by decode
    localparam logic [6:0] MUL_OPCODE = 7'b0010000;

    // Register clobbered as the shifted copy of rs
    localparam logic [3:0] SCRATCH_REG = 4'd15;

    // ST_MOVE is only entered by the fast single-word imm==1 path
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY,
        ST_CLEAR,
        ST_ADD,
        ST_SHL,
        ST_MOVE
    } state_e;

endpackage

// File: rtl/ucode_instr_pack.sv
// Combinational packer: instruction fields -> 32-bit word.
// src2 [16:13] overlaps imm [15:0]; callers never drive both non-zero.
module ucode_instr_pack
    import ucode_pkg::*;
(
    input  logic [1:0]  cls,
    input  logic        set_flags,
    input  logic [2:0]  func,
    input  logic [3:0]  dest,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic [15:0] imm,
    output logic [31:0] word
);

    // Special bit is always zero for generated words
    assign word = {cls, 1'b0, set_flags, func, dest, src1, 17'd0}
                | {15'd0, src2, 13'd0}
                | {16'd0, imm};

endmodule

// File: rtl/ucode_mul_expander.sv
// Expands MUL rd = rs * imm into a shift-and-add instruction sequence.
// Optional feature macro: UCODE_FASTZERO_EN (imm 0/1 emit a single word).
module ucode_mul_expander
    import ucode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_rs,
    input  logic [15:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_word,
    output logic        busy,
    output logic        err
);

    state_e      state_q, state_d;
    logic [3:0]  rd_q, rd_d;
    logic [3:0]  rs_q, rs_d;
    logic [15:0] rem_q, rem_d;
    logic        valid_q, valid_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;

    logic [1:0]  f_cls;
    logic [2:0]  f_func;
    logic [3:0]  f_dest, f_src1, f_src2;
    logic [15:0] f_imm;
    logic [31:0] packed_word;

    logic        handshake;
    assign handshake = valid_q && instr_ready;

    // Next-state logic; state only advances on an output handshake
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_rd == SCRATCH_REG) begin
                        err_d = 1'b1;
                    end else begin
                        rd_d  = req_rd;
                        rs_d  = req_rs;
                        rem_d = req_imm;
`ifdef UCODE_FASTZERO_EN
                        if (req_imm == 16'd0)      state_d = ST_CLEAR;
                        else if (req_imm == 16'd1) state_d = ST_MOVE;
                        else                       state_d = ST_COPY;
`else
                        state_d = ST_COPY;
`endif
                    end
                end
            end
            ST_COPY: begin
                if (handshake) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (handshake) begin
                    if (rem_q[0])                   state_d = ST_ADD;
                    else if (rem_q[15:1] != 15'd0)  state_d = ST_SHL;
                    else                            state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (handshake) begin
                    if (rem_q[15:1] != 15'd0) state_d = ST_SHL;
                    else                      state_d = ST_IDLE;
                end
            end
            ST_SHL: begin
                if (handshake) begin
                    rem_d   = rem_q >> 1;
                    state_d = rem_q[1] ? ST_ADD : ST_SHL;
                end
            end
            ST_MOVE: begin
                if (handshake) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Field mux for the word to be presented in the next state
    always_comb begin
        f_cls  = CLS_DIMM;
        f_func = ADD;
        f_dest = 4'd0;
        f_src1 = 4'd0;
        f_src2 = 4'd0;
        f_imm  = 16'd0;
        case (state_d)
            ST_COPY: begin
                f_dest = SCRATCH_REG;
                f_src1 = rs_d;
            end
            ST_CLEAR: begin
                f_func = MOV;
                f_dest = rd_d;
            end
            ST_ADD: begin
                f_cls  = CLS_DREG;
                f_dest = rd_d;
                f_src1 = rd_d;
                f_src2 = SCRATCH_REG;
            end
            ST_SHL: begin
                f_func = SHL;
                f_dest = SCRATCH_REG;
                f_src1 = SCRATCH_REG;
                f_imm  = 16'h0001;
            end
            ST_MOVE: begin
                f_dest = rd_d;
                f_src1 = rs_d;
            end
            default: ;
        endcase
    end

    ucode_instr_pack u_pack (
        .cls       (f_cls),
        .set_flags (1'b0),
        .func      (f_func),
        .dest      (f_dest),
        .src1      (f_src1),
        .src2      (f_src2),
        .imm       (f_imm),
        .word      (packed_word)
    );

    assign valid_d = (state_d != ST_IDLE);
    assign word_d  = valid_d ? packed_word : 32'd0;

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rd_q    <= 4'd0;
            rs_q    <= 4'd0;
            rem_q   <= 16'd0;
            valid_q <= 1'b0;
            word_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr_word  = word_q;
    assign err         = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign req_ready   = (state_q == ST_IDLE);

endmodule
